// File: rtl/multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// multi_pulse_generator
// Multi-channel pulse-train generator. Each channel waits an initial delay,
// then emits pulses of a programmed width separated by a programmed gap, for a
// programmed repetition count (0 = run until abort/reset). Configuration is
// captured when the channel starts, so the inputs may change mid-train.
//
// Optional feature: define MULTI_PULSE_GEN_SYNC_EN to add sync_start, which
// starts every channel in the same cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start[NUM_CH]         per-channel start / retrigger (level-sampled)
//   abort[NUM_CH]         per-channel abort, wins over start
//   delay_cycles          NUM_CH x CNT_W initial delay, channel i at [i*CNT_W +: CNT_W]
//   width_cycles          NUM_CH x CNT_W pulse width
//   gap_cycles            NUM_CH x CNT_W low time between pulses
//   repetition            NUM_CH x REP_W pulses per train, 0 = infinite
//   sync_start            (MULTI_PULSE_GEN_SYNC_EN only) start all channels
//   pulse_out[NUM_CH]     high in PULSE
//   busy[NUM_CH]          high when not IDLE
//   done[NUM_CH]          one-cycle strobe when a finite train completes
//   delay_led[NUM_CH]     high in DELAY
// -----------------------------------------------------------------------------
module multi_pulse_generator #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned REP_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH*CNT_W-1:0] delay_cycles,
    input  logic [NUM_CH*CNT_W-1:0] width_cycles,
    input  logic [NUM_CH*CNT_W-1:0] gap_cycles,
    input  logic [NUM_CH*REP_W-1:0] repetition,
`ifdef MULTI_PULSE_GEN_SYNC_EN
    input  logic                    sync_start,
`endif
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       delay_led
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e             state_q [NUM_CH];
    state_e             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [CNT_W-1:0]   width_q [NUM_CH];
    logic [CNT_W-1:0]   width_d [NUM_CH];
    logic [CNT_W-1:0]   gap_q   [NUM_CH];
    logic [CNT_W-1:0]   gap_d   [NUM_CH];
    logic [REP_W-1:0]   rep_q   [NUM_CH];
    logic [REP_W-1:0]   rep_d   [NUM_CH];
    logic [REP_W-1:0]   pcnt_q  [NUM_CH];
    logic [REP_W-1:0]   pcnt_d  [NUM_CH];
    logic [NUM_CH-1:0]  done_q;
    logic [NUM_CH-1:0]  done_d;
    logic [NUM_CH-1:0]  start_eff;

    // Effective per-channel start request
`ifdef MULTI_PULSE_GEN_SYNC_EN
    assign start_eff = start | {NUM_CH{sync_start}};
`else
    assign start_eff = start;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= '0;
                width_q[ch] <= '0;
                gap_q[ch]   <= '0;
                rep_q[ch]   <= '0;
                pcnt_q[ch]  <= '0;
            end
            done_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                width_q[ch] <= width_d[ch];
                gap_q[ch]   <= gap_d[ch];
                rep_q[ch]   <= rep_d[ch];
                pcnt_q[ch]  <= pcnt_d[ch];
            end
            done_q <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        done_d = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            logic [CNT_W-1:0] cfg_delay;
            logic [CNT_W-1:0] cfg_width;
            logic [REP_W-1:0] pcnt_inc;

            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            width_d[ch] = width_q[ch];
            gap_d[ch]   = gap_q[ch];
            rep_d[ch]   = rep_q[ch];
            pcnt_d[ch]  = pcnt_q[ch];

            cfg_delay = delay_cycles[ch*CNT_W +: CNT_W];
            cfg_width = width_cycles[ch*CNT_W +: CNT_W];
            // Pulses emitted including the one now ending; saturates, never wraps
            pcnt_inc  = (&pcnt_q[ch]) ? pcnt_q[ch] : pcnt_q[ch] + REP_W'(1);

            if (abort[ch]) begin
                state_d[ch] = ST_IDLE;
            end else if (start_eff[ch]) begin
                width_d[ch] = cfg_width;
                gap_d[ch]   = gap_cycles[ch*CNT_W +: CNT_W];
                rep_d[ch]   = repetition[ch*REP_W +: REP_W];
                pcnt_d[ch]  = '0;
                if (cfg_delay != '0) begin
                    state_d[ch] = ST_DELAY;
                    cnt_d[ch]   = cfg_delay;
                end else if (cfg_width != '0) begin
                    state_d[ch] = ST_PULSE;
                    cnt_d[ch]   = cfg_width;
                end else begin
                    state_d[ch] = ST_IDLE;
                    done_d[ch]  = 1'b1;
                end
            end else begin
                case (state_q[ch])
                    ST_DELAY: begin
                        if (cnt_q[ch] > CNT_W'(1)) begin
                            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                        end else if (width_q[ch] != '0) begin
                            state_d[ch] = ST_PULSE;
                            cnt_d[ch]   = width_q[ch];
                        end else begin
                            // Zero-width train after a delay completes empty
                            state_d[ch] = ST_IDLE;
                            done_d[ch]  = 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q[ch] > CNT_W'(1)) begin
                            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                        end else begin
                            pcnt_d[ch] = pcnt_inc;
                            if ((rep_q[ch] != '0) && (pcnt_inc == rep_q[ch])) begin
                                state_d[ch] = ST_IDLE;
                                done_d[ch]  = 1'b1;
                            end else if (gap_q[ch] != '0) begin
                                state_d[ch] = ST_GAP;
                                cnt_d[ch]   = gap_q[ch];
                            end else begin
                                cnt_d[ch]   = width_q[ch];
                            end
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q[ch] > CNT_W'(1)) begin
                            cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                        end else begin
                            state_d[ch] = ST_PULSE;
                            cnt_d[ch]   = width_q[ch];
                        end
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        pulse_out = '0;
        busy      = '0;
        delay_led = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            pulse_out[ch] = (state_q[ch] == ST_PULSE);
            busy[ch]      = (state_q[ch] != ST_IDLE);
            delay_led[ch] = (state_q[ch] == ST_DELAY);
        end
        done = done_q;
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_multi_pulse_generator
// Directed bench for multi_pulse_generator. Expected per-cycle outputs are
// derived from the closed-form train timing (delay, pulse k window, done
// cycle) and queued before each clock edge, then popped and compared after it.
// -----------------------------------------------------------------------------
module tb_multi_pulse_generator;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned REP_W  = 16;
    localparam int unsigned VW     = NUM_CH * 4;

    typedef struct {
        string         tag;
        int            cyc;
        logic [VW-1:0] val;
    } exp_t;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*CNT_W-1:0] delay_cycles;
    logic [NUM_CH*CNT_W-1:0] width_cycles;
    logic [NUM_CH*CNT_W-1:0] gap_cycles;
    logic [NUM_CH*REP_W-1:0] repetition;
    logic                    sync_start;
    logic [NUM_CH-1:0]       pulse_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       delay_led;

    exp_t sb[$];
    int   n_vec;
    int   n_fail;
    int   cyc;

    // Reference state: when each channel was last started and with what config
    bit   m_act [NUM_CH];
    int   m_t0  [NUM_CH];
    int   m_d   [NUM_CH];
    int   m_w   [NUM_CH];
    int   m_g   [NUM_CH];
    int   m_n   [NUM_CH];

    multi_pulse_generator #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .REP_W  (REP_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .delay_cycles (delay_cycles),
        .width_cycles (width_cycles),
        .gap_cycles   (gap_cycles),
        .repetition   (repetition),
`ifdef MULTI_PULSE_GEN_SYNC_EN
        .sync_start   (sync_start),
`endif
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done),
        .delay_led    (delay_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {pulse, busy, done, led} t cycles after the start-sampling edge
    function automatic logic [3:0] exp_ch(int t, int d, int w, int g, int n);
        int last;
        int ph;
        if (t < 1) return 4'b0000;
        if (d == 0 && w == 0) return (t == 1) ? 4'b0010 : 4'b0000;
        if (t <= d) return 4'b0101;
        if (n != 0) begin
            last = d + n * w + (n - 1) * g;
            if (t == last + 1) return 4'b0010;
            if (t > last) return 4'b0000;
        end
        ph = (t - d - 1) % (w + g);
        return (ph < w) ? 4'b1100 : 4'b0100;
    endfunction

    function automatic logic [VW-1:0] model_vec(int c);
        logic [VW-1:0] v;
        v = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m_act[ch]) v[ch*4 +: 4] = exp_ch(c - m_t0[ch], m_d[ch], m_w[ch], m_g[ch], m_n[ch]);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] observed();
        logic [VW-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            v[ch*4 +: 4] = {pulse_out[ch], busy[ch], done[ch], delay_led[ch]};
        end
        return v;
    endfunction

    task automatic set_cfg(input int ch, input int d, input int w, input int g, input int n);
        delay_cycles[ch*CNT_W +: CNT_W] = CNT_W'(d);
        width_cycles[ch*CNT_W +: CNT_W] = CNT_W'(w);
        gap_cycles[ch*CNT_W +: CNT_W]   = CNT_W'(g);
        repetition[ch*REP_W +: REP_W]   = REP_W'(n);
    endtask

    task automatic check();
        exp_t          e;
        logic [VW-1:0] obs;
        n_vec++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty cyc=%0d observed=none expected=entry", cyc);
        end else begin
            e   = sb.pop_front();
            obs = observed();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", e.tag, e.cyc, obs, e.val);
            end
        end
    endtask

    // Expect all outputs low now, without a clock edge
    task automatic check_zero(input string tag);
        exp_t e;
        e.tag = tag;
        e.cyc = cyc;
        e.val = '0;
        sb.push_back(e);
        check();
    endtask

    // Update the reference for the inputs about to be sampled, queue the
    // expectation for the next cycle, clock once and compare.
    task automatic tick(input string tag);
        logic [NUM_CH-1:0] st;
        exp_t              e;
        st = start;
`ifdef MULTI_PULSE_GEN_SYNC_EN
        st = st | {NUM_CH{sync_start}};
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (abort[ch]) begin
                m_act[ch] = 1'b0;
            end else if (st[ch]) begin
                m_act[ch] = 1'b1;
                m_t0[ch]  = cyc;
                m_d[ch]   = int'(delay_cycles[ch*CNT_W +: CNT_W]);
                m_w[ch]   = int'(width_cycles[ch*CNT_W +: CNT_W]);
                m_g[ch]   = int'(gap_cycles[ch*CNT_W +: CNT_W]);
                m_n[ch]   = int'(repetition[ch*REP_W +: REP_W]);
            end
        end
        e.tag = tag;
        e.cyc = cyc + 1;
        e.val = model_vec(cyc + 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        start      = '0;
        abort      = '0;
        sync_start = 1'b0;
        check();
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        start        = '0;
        abort        = '0;
        sync_start   = 1'b0;
        delay_cycles = '0;
        width_cycles = '0;
        gap_cycles   = '0;
        repetition   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_act[ch] = 1'b0;
            m_t0[ch]  = 0;
            m_d[ch]   = 0;
            m_w[ch]   = 0;
            m_g[ch]   = 0;
            m_n[ch]   = 0;
        end

        // Reset state
        #1;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run("idle_after_reset", 2);

        // Basic train on ch0: D=3 W=2 G=4 N=3
        set_cfg(0, 3, 2, 4, 3);
        start[0] = 1'b1;
        tick("basic_start");
        run("basic_train", 22);

        // Back-to-back pulses: D=0 W=1 G=0 N=4
        set_cfg(0, 0, 1, 0, 4);
        start[0] = 1'b1;
        tick("b2b_start");
        run("b2b_train", 7);

        // Zero width: immediate done
        set_cfg(3, 0, 0, 5, 2);
        start[3] = 1'b1;
        tick("w0_done");
        run("w0_idle", 3);

        // Infinite train on ch1, abort in cycle 101
        set_cfg(1, 0, 2, 2, 0);
        start[1] = 1'b1;
        tick("inf_start");
        run("inf_train", 100);
        abort[1] = 1'b1;
        tick("inf_abort");
        run("inf_after_abort", 6);

        // Start and abort together: stays idle
        set_cfg(0, 2, 3, 1, 2);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick("start_abort");
        run("start_abort_idle", 4);

        // Abort while idle has no effect
        abort = '1;
        tick("abort_idle");

        // Retrigger mid-pulse on ch2
        set_cfg(2, 5, 10, 0, 1);
        start[2] = 1'b1;
        tick("retrig_start");
        run("retrig_first", 8);
        set_cfg(2, 1, 3, 0, 1);
        start[2] = 1'b1;
        tick("retrig_reload");
        run("retrig_second", 7);

        // All channels concurrently, with a staggered retrigger and abort
        set_cfg(0, 2, 3, 1, 4);
        set_cfg(1, 0, 2, 3, 0);
        set_cfg(2, 7, 1, 2, 5);
        set_cfg(3, 1, 4, 0, 2);
        start = '1;
        tick("multi_start");
        run("multi_run", 5);
        set_cfg(3, 3, 2, 2, 3);
        start[3] = 1'b1;
        tick("multi_retrig3");
        run("multi_run2", 20);
        abort[1] = 1'b1;
        tick("multi_abort1");
        run("multi_tail", 8);

        // Asynchronous reset mid-pulse
        set_cfg(1, 0, 6, 1, 0);
        set_cfg(0, 1, 5, 1, 0);
        start = 4'b0011;
        tick("rst_setup");
        run("rst_setup_run", 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        for (int ch = 0; ch < NUM_CH; ch++) m_act[ch] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run("post_reset_idle", 3);

`ifdef MULTI_PULSE_GEN_SYNC_EN
        // Synchronous start of every channel with equal configurations
        for (int ch = 0; ch < NUM_CH; ch++) set_cfg(ch, 2, 2, 1, 2);
        sync_start = 1'b1;
        tick("sync_start");
        run("sync_run", 10);
        abort[2]   = 1'b1;
        sync_start = 1'b1;
        tick("sync_abort2");
        run("sync_run2", 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
